// File: rtl/audio_pkg.sv
// Shared definitions for the audio block-processing path: chunk geometry,
// sample/word widths and the chunk scheduler state encoding.
package audio_pkg;

  localparam int unsigned BUFF_SIZE   = 64;
  localparam int unsigned PTR_BITS    = 6;
  localparam int unsigned WORD_SIZE   = 32;
  localparam int unsigned SAMPLE_SIZE = 24;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRIME      = 2'd1,
    RUN        = 2'd2,
    WAIT_FIRST = 2'd3
  } sched_state_e;

endpackage

// File: rtl/chunk_addr_counter.sv
// Input-bank address generator: turns a sample strobe into a registered write
// enable/address one clock later, plus a wrap pulse on the last slot of a chunk.
module chunk_addr_counter #(
  parameter int unsigned BUFF_SIZE = 64,
  parameter int unsigned PTR_BITS  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_run,
  input  logic                i_stb,
  output logic                o_wr_en,
  output logic [PTR_BITS-1:0] o_wr_ptr,
  output logic                o_wrap
);

  localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(BUFF_SIZE - 1);

  logic [PTR_BITS-1:0] ptr_q, ptr_d;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic                wr_en_q, wr_en_d;
  logic                wrap_q, wrap_d;

  // Dropping i_run flushes any write or wrap still in flight.
  always_comb begin
    ptr_d    = ptr_q;
    wr_ptr_d = wr_ptr_q;
    wr_en_d  = 1'b0;
    wrap_d   = 1'b0;
    if (!i_run) begin
      ptr_d    = '0;
      wr_ptr_d = '0;
    end else if (i_stb) begin
      wr_en_d  = 1'b1;
      wr_ptr_d = ptr_q;
      if (ptr_q == PTR_LAST) begin
        wrap_d = 1'b1;
        ptr_d  = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      wr_en_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      wr_en_q  <= wr_en_d;
      wrap_q   <= wrap_d;
    end
  end

  assign o_wr_en  = wr_en_q;
  assign o_wr_ptr = wr_ptr_q;
  assign o_wrap   = wrap_q;

endmodule

// File: rtl/chunk_sched_ctrl.sv
// Ping-pong chunk scheduler: bank swap at each chunk boundary, processor
// start/done handshake, overrun tracking and tx mute until the first chunk.
module chunk_sched_ctrl
  import audio_pkg::*;
#(
  parameter int unsigned BUFF_SIZE    = audio_pkg::BUFF_SIZE,
  parameter int unsigned PTR_BITS     = audio_pkg::PTR_BITS,
  parameter int unsigned ERR_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic                    i_sample_stb,
  input  logic                    i_proc_done,
  input  logic                    i_clr_err,
  output logic                    o_wr_en,
  output logic [PTR_BITS-1:0]     o_wr_ptr,
  output logic                    o_buff_sel,
  output logic                    o_chunk_pulse,
  output logic                    o_proc_busy,
  output logic                    o_tx_mute,
  output logic                    o_overrun,
  output logic [ERR_CNT_BITS-1:0] o_overrun_cnt,
  output logic [1:0]              o_state
);

  sched_state_e            state_q;
  logic                    buff_sel_q;
  logic                    chunk_pulse_q;
  logic                    busy_q;
  logic                    mute_q;
  logic                    overrun_q;
  logic [ERR_CNT_BITS-1:0] cnt_q;

  logic                    run;
  logic                    wrap;
  logic                    done_ok;
  logic [ERR_CNT_BITS-1:0] cnt_base;
  logic [ERR_CNT_BITS-1:0] cnt_inc;

  assign run     = i_enable && (state_q != IDLE);
  assign done_ok = i_proc_done && busy_q;

  chunk_addr_counter #(
    .BUFF_SIZE (BUFF_SIZE),
    .PTR_BITS  (PTR_BITS)
  ) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (run),
    .i_stb    (i_sample_stb),
    .o_wr_en  (o_wr_en),
    .o_wr_ptr (o_wr_ptr),
    .o_wrap   (wrap)
  );

  // A clear coinciding with an overrun counts from zero, so the result is 1.
  always_comb begin
    cnt_base = i_clr_err ? '0 : cnt_q;
    cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      buff_sel_q    <= 1'b0;
      chunk_pulse_q <= 1'b0;
      busy_q        <= 1'b0;
      mute_q        <= 1'b1;
      overrun_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      chunk_pulse_q <= 1'b0;
      if (i_clr_err) begin
        overrun_q <= 1'b0;
        cnt_q     <= '0;
      end
      if (!i_enable || state_q == IDLE) begin
        state_q    <= i_enable ? PRIME : IDLE;
        buff_sel_q <= 1'b0;
        busy_q     <= 1'b0;
        mute_q     <= 1'b1;
      end else begin
        if (done_ok && state_q == WAIT_FIRST) begin
          state_q <= RUN;
          mute_q  <= 1'b0;
        end
        // At a boundary a same-cycle done frees the processor just in time.
        if (wrap) begin
          buff_sel_q <= ~buff_sel_q;
          if (busy_q && !i_proc_done) begin
            overrun_q <= 1'b1;
            cnt_q     <= cnt_inc;
          end else begin
            chunk_pulse_q <= 1'b1;
            busy_q        <= 1'b1;
          end
          if (state_q == PRIME) begin
            state_q <= WAIT_FIRST;
          end
        end else if (done_ok) begin
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign o_buff_sel    = buff_sel_q;
  assign o_chunk_pulse = chunk_pulse_q;
  assign o_proc_busy   = busy_q;
  assign o_tx_mute     = mute_q;
  assign o_overrun     = overrun_q;
  assign o_overrun_cnt = cnt_q;
  assign o_state       = state_q;

endmodule
